// File: rtl/bcd_display_driver.sv
// bcd_display_driver: latches BCD digits on each OUT strobe and drives three
// 7-segment displays. Leading zeros are blanked, out-of-range BCD codes show
// 'E', and values above 999 blink a row of dashes.
module bcd_display_driver #(
  parameter int BLINK_DIV      = 25000000,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        out_en,
  input  logic [31:0] binario,
  input  logic [3:0]  unidade,
  input  logic [3:0]  dezena,
  input  logic [3:0]  centena,
  output logic [6:0]  seg_u,
  output logic [6:0]  seg_d,
  output logic [6:0]  seg_c,
  output logic        displaying,
  output logic        ack
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_ERR   = 7'h79;
  localparam logic [6:0] POLARITY  = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

  // The overflow flag lives in the state itself: OVF means the captured
  // value was above 999, SHOW means it was not.
  typedef enum logic [1:0] {IDLE, SHOW, OVF} state_t;

  state_t        state;
  logic          out_q;
  logic          cap_q;
  logic [3:0]    hold_u;
  logic [3:0]    hold_d;
  logic [3:0]    hold_c;
  logic [CW-1:0] blink_cnt;
  logic          phase_hidden;
  logic          capture;
  logic [6:0]    next_u;
  logic [6:0]    next_d;
  logic [6:0]    next_c;

  function automatic logic [6:0] glyph(input logic [3:0] digit);
    case (digit)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = SEG_ERR;
    endcase
  endfunction

  assign capture = out_en & ~out_q;

  // Active-high glyphs for the next output edge, derived from the held value.
  always_comb begin
    next_u = SEG_BLANK;
    next_d = SEG_BLANK;
    next_c = SEG_BLANK;
    case (state)
      SHOW: begin
        next_u = glyph(hold_u);
        if (hold_c != 4'd0) begin
          next_c = glyph(hold_c);
        end
        if ((hold_c != 4'd0) || (hold_d != 4'd0)) begin
          next_d = glyph(hold_d);
        end
      end
      OVF: begin
        if (!phase_hidden) begin
          next_u = SEG_DASH;
          next_d = SEG_DASH;
          next_c = SEG_DASH;
        end
      end
      default: begin
        next_u = SEG_BLANK;
      end
    endcase
  end

  // Strobe edge detect, capture, blink timing and the registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      out_q        <= 1'b0;
      cap_q        <= 1'b0;
      hold_u       <= 4'd0;
      hold_d       <= 4'd0;
      hold_c       <= 4'd0;
      blink_cnt    <= '0;
      phase_hidden <= 1'b0;
      seg_u        <= POLARITY;
      seg_d        <= POLARITY;
      seg_c        <= POLARITY;
      displaying   <= 1'b0;
      ack          <= 1'b0;
    end else begin
      out_q      <= out_en;
      cap_q      <= capture;
      ack        <= cap_q;
      displaying <= (state != IDLE);
      seg_u      <= next_u ^ POLARITY;
      seg_d      <= next_d ^ POLARITY;
      seg_c      <= next_c ^ POLARITY;
      if (capture) begin
        hold_u       <= unidade;
        hold_d       <= dezena;
        hold_c       <= centena;
        state        <= (binario > 32'd999) ? OVF : SHOW;
        blink_cnt    <= '0;
        phase_hidden <= 1'b0;
      end else if (state == OVF) begin
        if (blink_cnt == CNT_LAST) begin
          blink_cnt    <= '0;
          phase_hidden <= ~phase_hidden;
        end else begin
          blink_cnt <= blink_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: drives two copies of the display driver (inverted
// and true segment polarity) from shared inputs and compares both against a
// behavioural model of the displays built from the capture history.
module tb_bcd_display_driver;

  localparam int BD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        out_en = 1'b0;
  logic [31:0] binario = 32'd0;
  logic [3:0]  unidade = 4'd0;
  logic [3:0]  dezena = 4'd0;
  logic [3:0]  centena = 4'd0;

  logic [6:0]  su_i, sd_i, sc_i, su_p, sd_p, sc_p;
  logic        disp_i, ack_i, disp_p, ack_p;

  int errors = 0;
  int checks = 0;

  // Model state: mode 0 = nothing captured, 1 = number shown, 2 = overflow.
  int          m_mode;
  logic        m_prev;
  logic        m_cap_last;
  logic [3:0]  m_u, m_d, m_c;
  int          edge_cnt;
  int          m_cap_edge;
  int          elapsed;
  logic [6:0]  e_u, e_d, e_c;
  logic        e_disp, e_ack;
  logic [6:0]  glyph_tab [16];

  logic [22:0] act_i, exp_i, act_p, exp_p;

  assign act_i = {sc_i, sd_i, su_i, disp_i, ack_i};
  assign act_p = {sc_p, sd_p, su_p, disp_p, ack_p};
  assign exp_i = {~e_c, ~e_d, ~e_u, e_disp, e_ack};
  assign exp_p = {e_c, e_d, e_u, e_disp, e_ack};

  always #5 clock = ~clock;

  bcd_display_driver #(.BLINK_DIV(BD), .ACTIVE_LOW_SEG(1'b1)) dut_inv (
    .clock(clock), .reset(reset), .out_en(out_en), .binario(binario),
    .unidade(unidade), .dezena(dezena), .centena(centena),
    .seg_u(su_i), .seg_d(sd_i), .seg_c(sc_i),
    .displaying(disp_i), .ack(ack_i)
  );

  bcd_display_driver #(.BLINK_DIV(BD), .ACTIVE_LOW_SEG(1'b0)) dut_pos (
    .clock(clock), .reset(reset), .out_en(out_en), .binario(binario),
    .unidade(unidade), .dezena(dezena), .centena(centena),
    .seg_u(su_p), .seg_d(sd_p), .seg_c(sc_p),
    .displaying(disp_p), .ack(ack_p)
  );

  initial begin
    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
  end

  // Reference: each edge shows what the last capture (before that edge) implies.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_prev = 1'b0; m_cap_last = 1'b0;
      m_u = 4'd0; m_d = 4'd0; m_c = 4'd0;
      edge_cnt = 0; m_cap_edge = 0;
      e_u = 7'h00; e_d = 7'h00; e_c = 7'h00; e_disp = 1'b0; e_ack = 1'b0;
    end else begin
      edge_cnt = edge_cnt + 1;
      e_ack  = m_cap_last;
      e_disp = (m_mode != 0);
      e_u = 7'h00; e_d = 7'h00; e_c = 7'h00;
      if (m_mode == 1) begin
        e_u = glyph_tab[m_u];
        if (m_c != 0) e_c = glyph_tab[m_c];
        if (m_c != 0 || m_d != 0) e_d = glyph_tab[m_d];
      end else if (m_mode == 2) begin
        elapsed = edge_cnt - m_cap_edge;
        if (((elapsed - 1) / BD) % 2 == 0) begin
          e_u = 7'h40; e_d = 7'h40; e_c = 7'h40;
        end
      end
      m_cap_last = out_en && !m_prev;
      if (m_cap_last) begin
        m_mode = (binario > 999) ? 2 : 1;
        m_u = unidade; m_d = dezena; m_c = centena;
        m_cap_edge = edge_cnt;
      end
      m_prev = out_en;
    end
  end

  // Presents one value and pulses the strobe for a single cycle.
  task automatic drive_capture(input logic [31:0] b, input logic [3:0] c,
                               input logic [3:0] d, input logic [3:0] u);
    binario = b; centena = c; dezena = d; unidade = u; out_en = 1'b1;
    @(negedge clock);
    out_en = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({sc_i, sd_i, su_i, disp_i, ack_i} !== {21'h1FFFFF, 2'b00}) begin
      errors++;
      $display("[TB] FAIL reset_held got=%h want=%h", act_i, {21'h1FFFFF, 2'b00});
    end
    reset = 1'b1;
    out_en = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({sc_i, sd_i, su_i, disp_i, ack_i} !== {21'h1FFFFF, 2'b00}) begin
      errors++;
      $display("[TB] FAIL reset_released got=%h want=%h", act_i, {21'h1FFFFF, 2'b00});
    end
    checks++;
    if ({sc_p, sd_p, su_p} !== 21'h0) begin
      errors++;
      $display("[TB] FAIL reset_pos got=%h want=0", {sc_p, sd_p, su_p});
    end
  endtask

  task automatic test_basic();
    drive_capture(32'd123, 4'd1, 4'd2, 4'd3);
    checks++;
    if (ack_i !== 1'b0 || disp_i !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_latency ack=%b disp=%b want 0 0", ack_i, disp_i);
    end
    @(negedge clock);
    checks++;
    if ({sc_i, sd_i, su_i, disp_i, ack_i} !== {~7'h06, ~7'h5B, ~7'h4F, 2'b11}) begin
      errors++;
      $display("[TB] FAIL basic_123 got=%h want=%h", act_i,
               {~7'h06, ~7'h5B, ~7'h4F, 2'b11});
    end
    @(negedge clock);
    checks++;
    if (ack_i !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_ack_clear got=%b want=0", ack_i);
    end
  endtask

  task automatic test_blanking();
    logic [31:0] b;
    logic [3:0]  c, d, u;
    logic [20:0] want;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin b = 32'd7;  c = 4'd0; d = 4'd0; u = 4'd7; want = {7'h00, 7'h00, 7'h07}; end
        1:       begin b = 32'd40; c = 4'd0; d = 4'd4; u = 4'd0; want = {7'h00, 7'h66, 7'h3F}; end
        default: begin b = 32'd0;  c = 4'd0; d = 4'd0; u = 4'd0; want = {7'h00, 7'h00, 7'h3F}; end
      endcase
      drive_capture(b, c, d, u);
      @(negedge clock);
      checks++;
      if ({sc_i, sd_i, su_i} !== ~want) begin
        errors++;
        $display("[TB] FAIL blank_%0d got=%h want=%h", b, {sc_i, sd_i, su_i}, ~want);
      end
      checks++;
      if (act_p !== exp_p) begin
        errors++;
        $display("[TB] FAIL blank_model_pos got=%h want=%h", act_p, exp_p);
      end
    end
  endtask

  task automatic test_overflow();
    logic [6:0] want;
    drive_capture(32'd1000, 4'd0, 4'd0, 4'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      want = (((k - 1) / BD) % 2 == 0) ? ~7'h40 : 7'h7F;
      checks++;
      if ({sc_i, sd_i, su_i} !== {want, want, want}) begin
        errors++;
        $display("[TB] FAIL ovf_blink_%0d got=%h want=%h", k, {sc_i, sd_i, su_i}, {want, want, want});
      end
      checks++;
      if (act_i !== exp_i) begin
        errors++;
        $display("[TB] FAIL ovf_model got=%h want=%h", act_i, exp_i);
      end
    end
    drive_capture(32'd5, 4'd0, 4'd0, 4'd5);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      checks++;
      if ({sc_i, sd_i, su_i, ack_i} !== {7'h7F, 7'h7F, ~7'h6D, (k == 1)}) begin
        errors++;
        $display("[TB] FAIL ovf_then_5_%0d got=%h want=%h", k, {sc_i, sd_i, su_i, ack_i},
                 {7'h7F, 7'h7F, ~7'h6D, (k == 1)});
      end
    end
  endtask

  task automatic test_held_strobe();
    int acks = 0;
    binario = 32'd456; centena = 4'd4; dezena = 4'd5; unidade = 4'd6; out_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (ack_i === 1'b1) acks++;
      checks++;
      if (act_i !== exp_i) begin
        errors++;
        $display("[TB] FAIL held_model got=%h want=%h", act_i, exp_i);
      end
      binario = $urandom % 1000;
      centena = 4'($urandom_range(1, 9));
      dezena  = 4'($urandom_range(0, 9));
      unidade = 4'($urandom_range(0, 9));
      if (k == 9) out_en = 1'b0;
    end
    repeat (2) begin
      @(negedge clock);
      if (ack_i === 1'b1) acks++;
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("[TB] FAIL held_ack_count got=%0d want=1", acks);
    end
    checks++;
    if ({sc_i, sd_i, su_i} !== {~7'h66, ~7'h6D, ~7'h7D}) begin
      errors++;
      $display("[TB] FAIL held_digits got=%h want=%h", {sc_i, sd_i, su_i}, {~7'h66, ~7'h6D, ~7'h7D});
    end
  endtask

  task automatic test_invalid();
    drive_capture(32'd3, 4'hC, 4'd0, 4'd3);
    @(negedge clock);
    checks++;
    if ({sc_i, sd_i, su_i} !== {~7'h79, ~7'h3F, ~7'h4F}) begin
      errors++;
      $display("[TB] FAIL invalid_bcd got=%h want=%h", {sc_i, sd_i, su_i}, {~7'h79, ~7'h3F, ~7'h4F});
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        @(negedge clock);
        if (ack_i === 1'b1) acks++;
        checks++;
        if (act_i !== exp_i) begin
          errors++;
          $display("[TB] FAIL b2b_model got=%h want=%h", act_i, exp_i);
        end
      end
      case (k)
        0:       begin binario = 32'd321; centena = 4'd3; dezena = 4'd2; unidade = 4'd1; out_en = 1'b1; end
        2:       begin binario = 32'd987; centena = 4'd9; dezena = 4'd8; unidade = 4'd7; out_en = 1'b1; end
        default: out_en = 1'b0;
      endcase
    end
    checks++;
    if (acks != 2) begin
      errors++;
      $display("[TB] FAIL b2b_ack_count got=%0d want=2", acks);
    end
    checks++;
    if ({sc_i, sd_i, su_i} !== {~7'h6F, ~7'h7F, ~7'h07}) begin
      errors++;
      $display("[TB] FAIL b2b_last_wins got=%h want=%h", {sc_i, sd_i, su_i}, {~7'h6F, ~7'h7F, ~7'h07});
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      checks++;
      if (act_i !== exp_i) begin
        errors++;
        $display("[TB] FAIL random_inv cyc=%0d got=%h want=%h", k, act_i, exp_i);
      end
      checks++;
      if (act_p !== exp_p) begin
        errors++;
        $display("[TB] FAIL random_pos cyc=%0d got=%h want=%h", k, act_p, exp_p);
      end
      out_en = ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom % 1000);
      binario = v;
      if ($urandom_range(0, 4) == 0) begin
        centena = 4'($urandom); dezena = 4'($urandom); unidade = 4'($urandom);
      end else begin
        centena = 4'((v % 1000) / 100); dezena = 4'((v % 100) / 10); unidade = 4'(v % 10);
      end
    end
    out_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_capture(32'd2000, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({sc_i, sd_i, su_i, disp_i, ack_i} !== {21'h1FFFFF, 2'b00}) begin
      errors++;
      $display("[TB] FAIL reset_mid_async got=%h want=%h", act_i, {21'h1FFFFF, 2'b00});
    end
    checks++;
    if ({sc_p, sd_p, su_p, disp_p, ack_p} !== 23'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_pos got=%h want=0", act_p);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if ({sc_i, sd_i, su_i, disp_i} !== {21'h1FFFFF, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset_mid_hold got=%h want=%h", {sc_i, sd_i, su_i, disp_i}, {21'h1FFFFF, 1'b0});
      end
    end
    drive_capture(32'd123, 4'd1, 4'd2, 4'd3);
    @(negedge clock);
    checks++;
    if ({sc_p, sd_p, su_p, ack_p} !== {7'h06, 7'h5B, 7'h4F, 1'b1}) begin
      errors++;
      $display("[TB] FAIL pos_basic got=%h want=%h", {sc_p, sd_p, su_p, ack_p}, {7'h06, 7'h5B, 7'h4F, 1'b1});
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_basic();
    test_blanking();
    test_overflow();
    test_held_strobe();
    test_invalid();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
